// File: rtl/fp_capture_pkg.sv
// Shared FP32 field constants and class tags for the result-capture path.
// Also used by the ALU checker, so keep the class encodings stable.
package fp_capture_pkg;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef logic [3:0] fp_class_t;

  localparam fp_class_t CLASS_NAN  = 4'b1000;
  localparam fp_class_t CLASS_INF  = 4'b0100;
  localparam fp_class_t CLASS_ZERO = 4'b0010;
  localparam fp_class_t CLASS_SUB  = 4'b0001;
  localparam fp_class_t CLASS_NORM = 4'b0000;

endpackage

// File: rtl/fp32_classify.sv
// Combinational IEEE-754 single-precision classifier; the sign bit is ignored.
module fp32_classify
  import fp_capture_pkg::*;
(
  input  logic [31:0] value,
  output fp_class_t   fp_class
);

  logic [EXP_W-1:0]  exp_field;
  logic [MANT_W-1:0] mant_field;

  assign exp_field  = value[30:23];
  assign mant_field = value[22:0];

  always_comb begin
    fp_class = CLASS_NORM;
    if (exp_field == EXP_MAX) begin
      fp_class = (mant_field != '0) ? CLASS_NAN : CLASS_INF;
    end else if (exp_field == '0) begin
      fp_class = (mant_field != '0) ? CLASS_SUB : CLASS_ZERO;
    end
  end

endmodule

// File: rtl/fp_result_capture.sv
// Captures ALU results on rising edges of storeData into a small tagged result
// memory, with a 1-cycle synchronous read port for dumping results afterwards.
module fp_result_capture
  import fp_capture_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned WRAP  = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          storeData,
  input  logic [31:0]   result,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data,
  output fp_class_t     rd_class,
  output logic          rd_valid,
  output logic [AW-1:0] wr_index,
  output logic [AW:0]   count,
  output logic          full,
  output logic          overflow
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [31:0] mem_reg [DEPTH];
  fp_class_t   cls_reg [DEPTH];

  logic      store_prev_reg;
  logic      store_pending_reg;
  logic      armed_reg;
  logic      store_rise;
  logic      do_write;
  fp_class_t result_class;

  fp32_classify u_classify (
    .value    (result),
    .fp_class (result_class)
  );

  // armed_reg stays low after reset until storeData is seen low, so a strobe
  // held high across reset deassertion is not mistaken for a new rising edge.
  assign store_rise = storeData && !store_prev_reg && armed_reg;
  assign full       = (count == FULL_COUNT);
  assign do_write   = store_pending_reg && (!full || (WRAP != 0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      store_prev_reg    <= 1'b0;
      store_pending_reg <= 1'b0;
      armed_reg         <= 1'b0;
      wr_index          <= '0;
      count             <= '0;
      overflow          <= 1'b0;
      rd_data           <= '0;
      rd_class          <= '0;
      rd_valid          <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
        cls_reg[i] <= '0;
      end
    end else begin
      store_prev_reg    <= storeData;
      armed_reg         <= armed_reg || !storeData;
      // Rising edges are at least two cycles apart, so a pending store always
      // commits on the very next edge.
      store_pending_reg <= store_rise;

      if (do_write) begin
        mem_reg[wr_index] <= result;
        cls_reg[wr_index] <= result_class;
        wr_index          <= wr_index + 1'b1;
      end

      if (store_pending_reg) begin
        if (full) begin
          overflow <= 1'b1;
        end else begin
          count <= count + 1'b1;
        end
      end

      // Reads see the pre-write contents when addressing the entry being written.
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data  <= mem_reg[rd_addr];
        rd_class <= cls_reg[rd_addr];
      end
    end
  end

endmodule

// File: tb/tb_fp_result_capture.sv
// Drives a WRAP=1 and a WRAP=0 instance with identical stimulus and checks both
// against an array/queue-level reference model of the result store.
module tb_fp_result_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic        storeData;
  logic [31:0] result;
  logic        rd_en;
  logic [3:0]  rd_addr;

  logic [31:0] rdd [2];
  logic [3:0]  rdc [2];
  logic        rdv [2];
  logic [3:0]  wri [2];
  logic [4:0]  cnt [2];
  logic        ful [2];
  logic        ovf [2];

  int checks = 0;
  int errors = 0;

  // Reference model: index 0 is the WRAP=1 instance, index 1 is WRAP=0.
  logic [31:0] m_mem  [2][16];
  bit          m_used [2][16];
  int          m_wr   [2];
  int          m_cnt  [2];
  bit          m_ovf  [2];
  logic [31:0] m_rdd  [2];
  logic [3:0]  m_rdc  [2];

  always #5 clk = ~clk;

  fp_result_capture #(.DEPTH(16), .AW(4), .WRAP(1)) u_wrap (
    .clk(clk), .reset(reset), .storeData(storeData), .result(result),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd[0]), .rd_class(rdc[0]),
    .rd_valid(rdv[0]), .wr_index(wri[0]), .count(cnt[0]), .full(ful[0]),
    .overflow(ovf[0])
  );

  fp_result_capture #(.DEPTH(16), .AW(4), .WRAP(0)) u_drop (
    .clk(clk), .reset(reset), .storeData(storeData), .result(result),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd[1]), .rd_class(rdc[1]),
    .rd_valid(rdv[1]), .wr_index(wri[1]), .count(cnt[1]), .full(ful[1]),
    .overflow(ovf[1])
  );

  function automatic logic [3:0] ref_class(input logic [31:0] v);
    int e;
    int m;
    e = int'((v >> 23) & 32'hFF);
    m = int'(v & 32'h7FFFFF);
    if (e == 255) return (m != 0) ? 4'b1000 : 4'b0100;
    if (e == 0)   return (m != 0) ? 4'b0001 : 4'b0010;
    return 4'b0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) begin
        m_mem[d][i]  = '0;
        m_used[d][i] = 1'b0;
      end
      m_wr[d]  = 0;
      m_cnt[d] = 0;
      m_ovf[d] = 1'b0;
      m_rdd[d] = '0;
      m_rdc[d] = '0;
    end
  endtask

  task automatic model_commit(input logic [31:0] v);
    for (int d = 0; d < 2; d++) begin
      bit do_wr;
      do_wr = (m_cnt[d] < 16) || (d == 0);
      if (m_cnt[d] >= 16) m_ovf[d] = 1'b1;
      else m_cnt[d]++;
      if (do_wr) begin
        m_mem[d][m_wr[d]]  = v;
        m_used[d][m_wr[d]] = 1'b1;
        m_wr[d] = (m_wr[d] + 1) % 16;
      end
    end
  endtask

  function automatic logic [3:0] exp_class(input int d, input int a);
    return m_used[d][a] ? ref_class(m_mem[d][a]) : 4'b0000;
  endfunction

  task automatic check_state(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s.wr_index[%0d]", tag, d), 64'(wri[d]), 64'(m_wr[d]));
      chk($sformatf("%s.count[%0d]", tag, d), 64'(cnt[d]), 64'(m_cnt[d]));
      chk($sformatf("%s.full[%0d]", tag, d), 64'(ful[d]), 64'(m_cnt[d] == 16));
      chk($sformatf("%s.overflow[%0d]", tag, d), 64'(ovf[d]), 64'(m_ovf[d]));
    end
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    model_reset();
    @(negedge clk) reset = 1'b0;
  endtask

  // Random junk sits on result at edge N so only the value present at the
  // commit edge N+1 can be captured.
  task automatic store(input logic [31:0] v);
    @(negedge clk);
    storeData = 1'b1;
    result    = $urandom;
    @(posedge clk);
    @(negedge clk) result = v;
    @(posedge clk);
    model_commit(v);
    @(negedge clk);
    storeData = 1'b0;
    result    = $urandom;
    @(posedge clk);
    #1;
    $display("store %08h -> wrap wr=%0d cnt=%0d | drop wr=%0d cnt=%0d", v, wri[0], cnt[0], wri[1], cnt[1]);
  endtask

  task automatic read(input int a, input string tag);
    @(negedge clk);
    rd_en   = 1'b1;
    rd_addr = 4'(a);
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      m_rdd[d] = m_mem[d][a];
      m_rdc[d] = exp_class(d, a);
      chk($sformatf("%s.rd_valid[%0d]", tag, d), 64'(rdv[d]), 64'(1));
      chk($sformatf("%s.rd_data[%0d]", tag, d), 64'(rdd[d]), 64'(m_rdd[d]));
      chk($sformatf("%s.rd_class[%0d]", tag, d), 64'(rdc[d]), 64'(m_rdc[d]));
    end
    $display("read addr %0d -> wrap %08h/%04b | drop %08h/%04b", a, rdd[0], rdc[0], rdd[1], rdc[1]);
    @(negedge clk) rd_en = 1'b0;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s.idle_valid[%0d]", tag, d), 64'(rdv[d]), 64'(0));
      chk($sformatf("%s.hold_data[%0d]", tag, d), 64'(rdd[d]), 64'(m_rdd[d]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] class_vals [5];
    logic [31:0] v;
    logic [31:0] old_val;
    class_vals[0] = 32'h401421e6;
    class_vals[1] = 32'h7fc00000;
    class_vals[2] = 32'h7f800000;
    class_vals[3] = 32'h80000000;
    class_vals[4] = 32'h00000001;

    reset = 1'b1; storeData = 1'b0; result = '0; rd_en = 1'b0; rd_addr = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_state("reset");
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset.rd_valid[%0d]", d), 64'(rdv[d]), 64'(0));
      chk($sformatf("reset.rd_data[%0d]", d), 64'(rdd[d]), 64'(0));
    end
    @(negedge clk) reset = 1'b0;

    // Class coverage
    for (int i = 0; i < 5; i++) store(class_vals[i]);
    check_state("class");
    for (int i = 0; i < 5; i++) read(i, $sformatf("class%0d", i));

    // Latency and no re-trigger while the strobe stays high
    do_reset();
    @(negedge clk);
    storeData = 1'b1;
    result    = 32'hc145d8ae;
    @(posedge clk);
    #1;
    check_state("lat_edgeN");
    @(posedge clk);
    model_commit(32'hc145d8ae);
    #1;
    check_state("lat_edgeN1");
    repeat (5) begin
      @(negedge clk) result = $urandom;
    end
    @(posedge clk);
    #1;
    check_state("lat_hold");
    @(negedge clk) storeData = 1'b0;
    read(0, "lat_rd0");
    read(1, "lat_rd1");

    // Wrap vs drop with 17 stores
    do_reset();
    for (int i = 0; i < 17; i++) begin
      store(32'h10 + 32'(i));
      if (i == 15) check_state("wrap16");
    end
    check_state("wrap17");
    read(0, "wrap_rd0");
    read(1, "wrap_rd1");

    // Read-before-write on address 3 (WRAP=1 instance reaches index 3)
    store(32'h00001111);
    store(32'h00002222);
    check_state("rbw_pre");
    @(negedge clk);
    storeData = 1'b1;
    result    = $urandom;
    @(posedge clk);
    @(negedge clk);
    result  = 32'hABCD1234;
    rd_en   = 1'b1;
    rd_addr = 4'd3;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      old_val = m_mem[d][3];
      chk($sformatf("rbw_old[%0d]", d), 64'(rdd[d]), 64'(old_val));
      chk($sformatf("rbw_old_cls[%0d]", d), 64'(rdc[d]), 64'(exp_class(d, 3)));
    end
    $display("rbw addr 3 same-cycle -> wrap %08h | drop %08h", rdd[0], rdd[1]);
    model_commit(32'hABCD1234);
    @(negedge clk);
    storeData = 1'b0;
    rd_en     = 1'b0;
    read(3, "rbw_new");

    // Async reset between strobe rise and commit; strobe held across deassert
    @(negedge clk);
    storeData = 1'b1;
    result    = 32'h3f800000;
    @(posedge clk);
    #2 reset = 1'b1;
    model_reset();
    #1;
    check_state("arst_now");
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("arst.rd_data[%0d]", d), 64'(rdd[d]), 64'(0));
      chk($sformatf("arst.rd_class[%0d]", d), 64'(rdc[d]), 64'(0));
    end
    $display("async reset asserted -> cnt %0d/%0d rd_data %08h", cnt[0], cnt[1], rdd[0]);
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_state("arst_held");
    @(negedge clk) storeData = 1'b0;
    read(0, "arst_rd0");
    store(32'h3f800000);
    check_state("arst_after");

    // Randomized stores and reads against the model
    do_reset();
    for (int i = 0; i < 40; i++) begin
      int kind;
      kind = $urandom_range(0, 5);
      v = $urandom;
      case (kind)
        1: v[30:23] = 8'hFF;
        2: begin v[30:23] = 8'hFF; v[22:0] = '0; end
        3: v[30:23] = 8'h00;
        4: begin v[30:0] = '0; end
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) begin
        read($urandom_range(0, 15), $sformatf("rnd_rd%0d", i));
      end else begin
        store(v);
        check_state($sformatf("rnd_st%0d", i));
      end
    end
    for (int a = 0; a < 16; a++) read(a, $sformatf("dump%0d", a));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_result_capture.md
Name: fp_result_capture

Overview:
- Result-side counterpart to the FP ALU operand feeder.
- Samples the ALU's 32-bit result on each rising edge of a store strobe and writes it into a 16-entry result memory.
- Tags each stored word with an IEEE-754 single-precision class.
- Exposes a synchronous read port so the bench or a host can dump results after a run.

Parameters:
DEPTH, 16, number of result entries; power of two.
AW, 4, address/index width; log2(DEPTH).
WRAP, 1, 1 = overwrite oldest entries after the last index; 0 = drop writes when full.

Ports:
clk  in  1  system clock, all state on posedge.
reset  in  1  asynchronous, active-high; clears all state.
storeData  in  1  store request; level input, only its rising edge acts.
result  in  32  FP32 result from the ALU.
rd_en  in  1  read request.
rd_addr  in  AW  read address.
rd_data  out  32  stored result word.
rd_class  out  4  class tag of the read entry.
rd_valid  out  1  rd_data/rd_class valid this cycle.
wr_index  out  AW  next write index.
count  out  AW+1  entries written, saturating at DEPTH.
full  out  1  count == DEPTH.
overflow  out  1  sticky; a store happened while full.

Behaviour:
- Reset (async, active-high) clears:
  - rd_data, rd_class, rd_valid, wr_index, count, full, overflow, the internal storeData_prev and store_pending registers;
  - all memory and class entries, to 0.
- Edge detect:
  - At posedge N, if storeData=1 and storeData_prev=0, set store_pending.
  - storeData_prev <= storeData every cycle.
- Write:
  - At posedge N+1 with store_pending=1, capture `result` as sampled at that edge and clear store_pending.
  - Store-to-commit latency is therefore 2 edges from storeData rising.
  - Back-to-back rising edges are at least 2 cycles apart, so store_pending never overlaps itself.
- Write when not full:
  - mem[wr_index] <= result; cls[wr_index] <= classify(result).
  - wr_index increments; it wraps DEPTH-1 -> 0.
  - count increments.
- Write when full, WRAP=1:
  - Write and advance wr_index as above.
  - count stays at DEPTH; overflow <= 1.
- Write when full, WRAP=0:
  - No write; wr_index and count unchanged; overflow <= 1.
- full is combinational from count. overflow clears only on reset.
- Classify (combinational on result), with e = bits[30:23] and m = bits[22:0]:
  - NaN: e=FF, m!=0 -> 4'b1000.
  - Inf: e=FF, m=0 -> 4'b0100.
  - Zero: e=0, m=0 -> 4'b0010.
  - Subnormal: e=0, m!=0 -> 4'b0001.
  - Normal -> 4'b0000.
  - The sign bit is ignored for classification.
- Read:
  - rd_en=1 at posedge N -> rd_data/rd_class from mem[rd_addr] and rd_valid=1 after edge N, i.e. 1-cycle latency.
  - rd_en=0 -> rd_valid=0 and rd_data/rd_class hold their last value.
- Read/write to the same address in the same cycle returns the old contents (read-before-write).
- Reading an unwritten entry returns 0 with class 0000.
- Reset mid-operation: a pending store is discarded, and storeData held high across reset deassert does not trigger a store.

Decomposition:
- Shared package fp_capture_pkg holds:
  - FP32 field constants: EXP_W=8, MANT_W=23, EXP_MAX=8'hFF;
  - class constants CLASS_NAN, CLASS_INF, CLASS_ZERO, CLASS_SUB, CLASS_NORM.
- One combinational sub-module, fp32_classify (result in, 4-bit class out), is reused later by the ALU checker.

Test Plan:
- Class coverage: store 0x401421e6, 0x7fc00000, 0x7f800000, 0x80000000, 0x00000001, then read addresses 0-4. Required classes: 0000, 1000, 0100, 0010, 0001. count=5, wr_index=5.
- Latency: raise storeData at edge N with result=0xc145d8ae. mem[0] must be written at edge N+1. Holding storeData high for 5 more cycles produces no extra writes.
- Wrap, WRAP=1: 17 stores with results 0x00000010..0x00000020. full=1 after the 16th store. The 17th store writes addr 0 = 0x00000020; count=16, overflow=1, wr_index=1.
- Drop, WRAP=0: same 17 stores. addr 0 stays 0x00000010, wr_index=0, overflow=1.
- Read-before-write: rd_en on addr 3 in the commit cycle of a write to addr 3. rd_data must return the prior value, then the new value on the next read.
- Async reset: assert reset between the storeData rise and the commit. Outputs clear immediately, with no clock edge needed; no write occurs; count=0.
